// File: rtl/li_pkg.sv
`default_nettype none
// ============================================================================
// Module      : li_pkg
// Description : Shared types for the latency-insensitive FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package li_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2
  } li_state_t;

endpackage
`default_nettype wire

// File: rtl/scdpram_infer.sv
`default_nettype none
// ============================================================================
// Module      : scdpram_infer
// Description : Simple dual-port RAM, one-cycle registered read, new data
//               returned on read-during-write to the same address.
// Revision    : 1.0 - initial release
// ============================================================================
module scdpram_infer #(
  parameter int WIDTH = 10,
  parameter int ADDR  = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ADDR-1:0]  i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [ADDR-1:0]  i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [0:(2**ADDR)-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    // Bypass keeps a word written this edge visible to a same-address read.
    if (i_we && (i_waddr == i_raddr)) begin
      r_rdata <= i_wdata;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/li_fifo.sv
`default_nettype none
// ============================================================================
// Module      : li_fifo
// Description : Valid/ready FIFO over a registered-read RAM; the head word is
//               presented straight from the RAM output register.
// Revision    : 1.0 - initial release
// ============================================================================
module li_fifo
  import li_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int ADDR  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_valid,
  input  logic               i_ready,
  input  logic               i_flush,
  output logic [ADDR:0]      o_count
);

  localparam int c_DEPTH = 2**ADDR;
  localparam int c_CNT_W = ADDR + 1;

  li_state_t          r_state;
  logic [ADDR-1:0]    r_wr_ptr;
  logic [ADDR-1:0]    r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_valid;
  logic               r_ready;

  logic               w_push;
  logic               w_pop;
  logic               w_more;
  logic [ADDR-1:0]    w_raddr;
  logic [c_CNT_W-1:0] w_count_nxt;

  assign w_push = i_valid & r_ready & ~i_flush;
  assign w_pop  = r_valid & i_ready & ~i_flush;
  // Another word follows the head if one is stored or is being written now.
  assign w_more  = (r_count > c_CNT_W'(1)) | w_push;
  assign w_raddr = w_pop ? (r_rd_ptr + ADDR'(1)) : r_rd_ptr;

  always_comb begin
    w_count_nxt = r_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_EMPTY;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != c_CNT_W'(c_DEPTH));
      if (i_flush) begin
        r_state  <= S_EMPTY;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_valid  <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ADDR'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR'(1);
        case (r_state)
          S_EMPTY: begin
            if (w_push) r_state <= S_FETCH;
          end
          S_FETCH: begin
            r_state <= S_VALID;
            r_valid <= 1'b1;
          end
          S_VALID: begin
            if (w_pop && !w_more) begin
              r_state <= S_EMPTY;
              r_valid <= 1'b0;
            end
          end
          default: begin
            r_state <= S_EMPTY;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  scdpram_infer #(
    .WIDTH (WIDTH),
    .ADDR  (ADDR)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_data),
    .i_raddr (w_raddr),
    .o_rdata (o_data)
  );

  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_li_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_li_fifo
// Description : Directed scoreboard bench for li_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_li_fifo;

  localparam int c_WIDTH = 10;
  localparam int c_ADDR  = 4;
  localparam int c_DEPTH = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [c_WIDTH-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic [c_WIDTH-1:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic               i_flush;
  logic [c_ADDR:0]    o_count;

  logic [c_WIDTH-1:0] q[$];
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic               last_push;

  li_fifo #(.WIDTH(c_WIDTH), .ADDR(c_ADDR)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .i_flush (i_flush),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshakes seen before the edge, then check after it.
  task automatic tick();
    logic               push;
    logic               pop;
    logic               stall;
    logic [c_WIDTH-1:0] held;
    push  = i_valid && o_ready && !i_flush;
    pop   = o_valid && i_ready && !i_flush;
    stall = o_valid && !i_ready && !i_flush;
    held  = o_data;
    if (pop) begin
      chk("pop_has_data", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) chk("pop_order", 32'(o_data), 32'(q.pop_front()));
    end
    if (i_flush) q.delete();
    else if (push) q.push_back(i_data);
    last_push = push;
    @(posedge clk);
    #1;
    if (stall) begin
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_data", 32'(o_data), 32'(held));
    end
    chk("count", 32'(o_count), 32'(q.size()));
    chk("ready", 32'(o_ready), 32'(q.size() != c_DEPTH));
    if (q.size() == 0) chk("valid_when_empty", 32'(o_valid), 32'd0);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int n = 0; n < 40 && q.size() != 0; n++) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
    i_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    i_data  = '0;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    reset = 1'b0;
    tick();

    // Single push into empty FIFO: one bubble cycle.
    i_data  = 10'h155;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk("single_e0_valid", 32'(o_valid), 32'd0);
    tick();
    chk("single_e1_valid", 32'(o_valid), 32'd1);
    chk("single_e1_data", 32'(o_data), 32'h155);
    drain();

    // Fill to full, then offer a 17th word that must be ignored.
    i_valid = 1'b1;
    for (int k = 0; k < c_DEPTH; k++) begin
      i_data = 10'(10'h200 + k);
      tick();
    end
    chk("full_count", 32'(o_count), 32'd16);
    chk("full_ready", 32'(o_ready), 32'd0);
    i_data = 10'h3FF;
    tick();
    chk("full_ignored", 32'(last_push), 32'd0);
    drain();

    // Streaming: one in, one out per cycle.
    i_valid = 1'b1;
    i_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      i_data = 10'(k);
      tick();
      if (k >= 1) chk("stream_valid", 32'(o_valid), 32'd1);
    end
    drain();

    // Backpressure with ~30% downstream ready.
    begin
      int pushed = 0;
      int cyc    = 0;
      while ((pushed < 200 || q.size() != 0) && cyc < 3000) begin
        i_valid = (pushed < 200);
        i_data  = 10'(10'h100 + pushed);
        i_ready = ($urandom_range(0, 9) < 3);
        tick();
        if (last_push) pushed++;
        cyc++;
      end
      chk("bp_complete", 32'((pushed == 200) && (q.size() == 0)), 32'd1);
    end
    i_ready = 1'b0;
    drain();

    // Flush with 5 held and a same-edge push and pop.
    i_ready = 1'b0;
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_data = 10'(10'h030 + k);
      tick();
    end
    chk("flush_pre_valid", 32'(o_valid), 32'd1);
    i_data  = 10'h03A;
    i_ready = 1'b1;
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    i_ready = 1'b0;
    chk("flush_count", 32'(o_count), 32'd0);
    chk("flush_valid", 32'(o_valid), 32'd0);
    i_data = 10'h0AA;
    tick();
    i_valid = 1'b0;
    chk("flush_e0_valid", 32'(o_valid), 32'd0);
    tick();
    chk("flush_e1_valid", 32'(o_valid), 32'd1);
    chk("flush_e1_data", 32'(o_data), 32'h0AA);
    drain();

    // Asynchronous reset with 7 words held.
    i_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      i_data = 10'(10'h050 + k);
      tick();
    end
    i_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(o_valid), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd0);
    chk("arst_count", 32'(o_count), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("arst_rel_count", 32'(o_count), 32'd0);
    tick();
    i_data  = 10'h011;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    chk("arst_new_valid", 32'(o_valid), 32'd1);
    chk("arst_new_data", 32'(o_data), 32'h011);
    drain();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
